// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmitter: start bit, LSB-first data, optional parity, stop bit
//
// Ports:
//   clk        rising-edge clock
//   tx_arst_n  asynchronous active-low reset (highest priority)
//   tx_rst     synchronous reset, same effect as tx_arst_n
//   tx_en      gates acceptance of new frames only
//   tx_start   frame request, sampled in IDLE
//   tx_data    DATA_W-bit payload, captured on the acceptance edge
//   tx         registered serial line, idles high
//   busy_flag  registered, high while START/DATA/PARITY/STOP
//   done_flag  registered, one-cycle pulse in DONE
module uart_tx_fsm #(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              tx_arst_n,
  input  logic              tx_rst,
  input  logic              tx_en,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              busy_flag,
  output logic              done_flag
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     baud_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_shr;
  logic              parity_q;
  logic              accept;
  logic              bit_end;
  logic              tx_d;
  logic              busy_d;
  logic              done_d;

  assign accept    = (state == S_IDLE) && tx_en && tx_start;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign shift_shr = shift_q >> 1;

  // State register
  always_ff @(posedge clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      state <= S_IDLE;
    end else if (tx_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_cnt == BIT_LAST)) begin
          state_nxt = PAR_ON ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: baud counter, bit counter, shift register, parity
  always_ff @(posedge clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else if (tx_rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (accept) begin
            shift_q  <= tx_data;
            parity_q <= (^tx_data) ^ ODD;
            bit_cnt  <= '0;
          end
        end
        S_START, S_PARITY, S_STOP: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        end
        S_DATA: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
          if (bit_end) begin
            shift_q <= shift_shr;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: baud_cnt <= '0;
      endcase
    end
  end

  // Output logic: computed from the upcoming state so the registered outputs
  // line up with the state they describe, with no input-to-output path.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      S_START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_DATA: begin
        // On a bit boundary inside DATA the next bit is the one about to shift in.
        tx_d   = (state == S_DATA && bit_end) ? shift_shr[0] : shift_q[0];
        busy_d = 1'b1;
      end
      S_PARITY: begin
        tx_d   = parity_q;
        busy_d = 1'b1;
      end
      S_STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_DONE: begin
        tx_d   = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      tx        <= 1'b1;
      busy_flag <= 1'b0;
      done_flag <= 1'b0;
    end else if (tx_rst) begin
      tx        <= 1'b1;
      busy_flag <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      tx        <= tx_d;
      busy_flag <= busy_d;
      done_flag <= done_d;
    end
  end

endmodule
